// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline stall / flush controller for a 5-stage MIPS-style core.
//
// Decides each cycle whether the front end advances, stalls, or is redirected
// to the exception handler or the EPC. It also tracks how long the multi-cycle
// multiply/divide unit stays busy.
//
// Ports
//   clk        in   1   pipeline clock; all state changes on the rising edge
//   reset      in   1   synchronous, active-high reset
//   stall_hzd  in   1   D-stage operand hazard (source not yet forwardable)
//   d_uses_md  in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//   md_start   in   1   E-stage mult/div issuing this cycle
//   md_is_div  in   1   qualifies md_start: 1 = div/divu, 0 = mult/multu
//   exc_req    in   1   CP0 exception/interrupt request from the M stage
//   eret_m     in   1   eret resident in the M stage
//   f_en       out  1   PC register enable
//   d_en       out  1   F/D register enable
//   e_clr      out  1   D/E register bubble insert
//   req        out  1   flush F/D, D/E, E/M and M/W; the PC loads the handler
//   pc_sel     out  2   next PC: 00 sequential/branch, 01 handler 0x0000_4180,
//                       10 EPC
//   md_busy    out  1   multiply/divide unit occupied
//   stall_cnt  out  32  number of stalled cycles
//
// Build option
//   PIPE_PERF_CNT_EN  When defined, stall_cnt is a free-running, wrapping
//                     count of stalled cycles. When undefined, stall_cnt is
//                     tied to zero and no counter flops are built.
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_hzd,
  input  logic        d_uses_md,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        exc_req,
  input  logic        eret_m,
  output logic        f_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        req,
  output logic [1:0]  pc_sel,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_HANDLER = 2'b01;
  localparam logic [1:0] PC_EPC     = 2'b10;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] md_cnt_reg;
  logic [3:0] md_cnt_next;
  logic       md_busy_int;
  logic       stall;
  logic       redirect;

  // The md unit stays busy while its countdown is nonzero.
  assign md_busy_int = (md_cnt_reg != 4'd0);

  // A D-stage md instruction must wait while the unit is busy. It must also
  // wait when a new mult/div issues in E this very cycle. The FLUSH cycle
  // only carries squashed instructions, so it never stalls.
  assign stall = (stall_hzd | (d_uses_md & (md_busy_int | md_start)))
                 & (state_reg != FLUSH);

  assign redirect = exc_req | eret_m;

  // Multiply/divide countdown. A start that coincides with an exception
  // belongs to an instruction that is being flushed, so it is dropped. An
  // operation already in flight keeps counting, because the hardware unit
  // cannot be cancelled.
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (md_start && !exc_req) begin
      md_cnt_next = md_is_div ? DIV_CYCLES : MULT_CYCLES;
    end else if (md_busy_int) begin
      md_cnt_next = md_cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_reg <= 4'd0;
    end else begin
      md_cnt_reg <= md_cnt_next;
    end
  end

  // Control FSM. A redirect (exception or eret) always wins and costs exactly
  // one FLUSH cycle. Back-to-back redirects keep the FSM in FLUSH.
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = FLUSH;
    end else begin
      case (state_reg)
        RUN:     state_next = stall ? STALL : RUN;
        STALL:   state_next = stall ? STALL : RUN;
        FLUSH:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pipeline enables and redirect. These are combinational, so they act in
  // the same cycle as the condition that causes them. While in reset, the
  // pipeline is held in a benign "advance, no flush" configuration.
  always_comb begin
    f_en    = 1'b1;
    d_en    = 1'b1;
    e_clr   = 1'b0;
    req     = 1'b0;
    pc_sel  = PC_SEQ;
    md_busy = 1'b0;
    if (!reset) begin
      md_busy = md_busy_int;
      if (exc_req) begin
        // Everything behind M is flushed by req, so a pending stall is moot.
        req    = 1'b1;
        pc_sel = PC_HANDLER;
      end else if (eret_m) begin
        // Fetch from the EPC. D keeps loading, so the wrong-path instruction
        // in D is dropped into a bubble instead of entering E.
        pc_sel = PC_EPC;
        e_clr  = 1'b1;
      end else if (stall) begin
        f_en  = 1'b0;
        d_en  = 1'b0;
        e_clr = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counter. It counts every cycle whose raw stall term is set
  // and wraps naturally at 2^32.
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
    end else if (stall) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed, self-checking bench for pipe_ctrl.
//
// Each step drives one cycle of inputs. The cycle's expected outputs go into
// a scoreboard queue, and they are popped and compared on the falling edge
// of that same cycle. The checks cover the outputs, the FSM state and
// stall_cnt. Build with +define+PIPE_PERF_CNT_EN to exercise the counter.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_hzd;
  logic        d_uses_md;
  logic        md_start;
  logic        md_is_div;
  logic        exc_req;
  logic        eret_m;
  logic        f_en;
  logic        d_en;
  logic        e_clr;
  logic        req;
  logic [1:0]  pc_sel;
  logic        md_busy;
  logic [31:0] stall_cnt;

  pipe_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall_hzd (stall_hzd),
    .d_uses_md (d_uses_md),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .exc_req   (exc_req),
    .eret_m    (eret_m),
    .f_en      (f_en),
    .d_en      (d_en),
    .e_clr     (e_clr),
    .req       (req),
    .pc_sel    (pc_sel),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // FSM encodings. DC skips the state check.
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DC    = 2'd3;

  // Input vector:  {reset, stall_hzd, d_uses_md, md_start, md_is_div, exc_req, eret_m}
  // Output vector: {f_en, d_en, e_clr, req, pc_sel[1:0], md_busy}
  localparam logic [6:0] O_NORM  = 7'b1100000;
  localparam logic [6:0] O_NORMB = 7'b1100001;
  localparam logic [6:0] O_STL   = 7'b0010000;
  localparam logic [6:0] O_STLB  = 7'b0010001;
  localparam logic [6:0] O_EXC   = 7'b1101010;
  localparam logic [6:0] O_EXCB  = 7'b1101011;
  localparam logic [6:0] O_ERET  = 7'b1110100;

  typedef struct {
    string       tag;
    logic [6:0]  outs;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, queue the expected values, then compare
  // on the falling edge.
  task automatic cyc(input string tag, input logic [6:0] in,
                     input logic [6:0] outs, input logic [1:0] st,
                     input logic stl);
    exp_t e;
    exp_t g;
    logic [1:0] obs_state;
    {reset, stall_hzd, d_uses_md, md_start, md_is_div, exc_req, eret_m} = in;
    e.tag  = tag;
    e.outs = outs;
    e.st   = st;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk(g.tag, "f_en",    {31'd0, f_en},    {31'd0, g.outs[6]});
    chk(g.tag, "d_en",    {31'd0, d_en},    {31'd0, g.outs[5]});
    chk(g.tag, "e_clr",   {31'd0, e_clr},   {31'd0, g.outs[4]});
    chk(g.tag, "req",     {31'd0, req},     {31'd0, g.outs[3]});
    chk(g.tag, "pc_sel",  {30'd0, pc_sel},  {30'd0, g.outs[2:1]});
    chk(g.tag, "md_busy", {31'd0, md_busy}, {31'd0, g.outs[0]});
    chk(g.tag, "stall_cnt", stall_cnt, g.cnt);
    if (g.st != DC) begin
      obs_state = dut.state_reg;
      chk(g.tag, "state", {30'd0, obs_state}, {30'd0, g.st});
    end
    if (in[6]) begin
      exp_cnt = 32'd0;
    end else if (stl) begin
`ifdef PIPE_PERF_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    {reset, stall_hzd, d_uses_md, md_start, md_is_div, exc_req, eret_m} = 7'b1000000;
    @(posedge clk);
    #1;

    // Reset: the outputs are forced to safe values even with every input set.
    cyc("rst0",     7'b1000000, O_NORM, DC,  1'b0);
    cyc("rst_junk", 7'b1111111, O_NORM, RUN, 1'b0);
    cyc("idle0",    7'b0000000, O_NORM, RUN, 1'b0);

    // Operand hazard for two cycles.
    cyc("hzd1",     7'b0100000, O_STL,  RUN,   1'b1);
    cyc("hzd2",     7'b0100000, O_STL,  STALL, 1'b1);
    cyc("hzd_rel",  7'b0000000, O_NORM, STALL, 1'b0);
    cyc("hzd_run",  7'b0000000, O_NORM, RUN,   1'b0);

    // Divide, with a dependent md instruction in D: 10 stalled cycles.
    cyc("div_iss",  7'b0001100, O_NORM, RUN, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc($sformatf("div_stl%0d", i), 7'b0010000, O_STLB, (i == 1) ? RUN : STALL, 1'b1);
    end
    cyc("div_rel",  7'b0010000, O_NORM, STALL, 1'b0);
    cyc("div_run",  7'b0000000, O_NORM, RUN,   1'b0);

    // Multiply: busy for 5 cycles, with no dependent instruction.
    cyc("mul_iss",  7'b0001000, O_NORM, RUN, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc($sformatf("mul_busy%0d", i), 7'b0000000, O_NORMB, RUN, 1'b0);
    end
    cyc("mul_done", 7'b0000000, O_NORM, RUN, 1'b0);

    // Exception during an md-induced stall. The count keeps running through FLUSH.
    cyc("xdiv_iss", 7'b0001100, O_NORM, RUN, 1'b0);
    cyc("xdiv_s1",  7'b0010000, O_STLB, RUN,   1'b1);
    cyc("xdiv_s2",  7'b0010000, O_STLB, STALL, 1'b1);
    cyc("xdiv_s3",  7'b0010000, O_STLB, STALL, 1'b1);
    cyc("xdiv_exc", 7'b0010010, O_EXCB, STALL, 1'b1);
    cyc("xdiv_fl",  7'b0010000, O_NORMB, FLUSH, 1'b0);
    cyc("xdiv_run", 7'b0010000, O_STLB,  RUN,   1'b1);
    cyc("xdiv_c4",  7'b0000000, O_NORMB, STALL, 1'b0);
    for (int i = 3; i >= 1; i--) begin
      cyc($sformatf("xdiv_c%0d", i), 7'b0000000, O_NORMB, RUN, 1'b0);
    end
    cyc("xdiv_done", 7'b0000000, O_NORM, RUN, 1'b0);

    // md_start in the same cycle as an exception is dropped.
    cyc("mdx_iss",  7'b0001110, O_EXC,  RUN,   1'b0);
    cyc("mdx_fl",   7'b0000000, O_NORM, FLUSH, 1'b0);
    cyc("mdx_run",  7'b0000000, O_NORM, RUN,   1'b0);

    // Exception and eret together: the exception wins.
    cyc("xe_both",  7'b0000011, O_EXC,  RUN,   1'b0);
    cyc("xe_fl",    7'b0000000, O_NORM, FLUSH, 1'b0);
    cyc("xe_run",   7'b0000000, O_NORM, RUN,   1'b0);

    // eret alone. A hazard in the FLUSH cycle is masked.
    cyc("eret",     7'b0000001, O_ERET, RUN,   1'b0);
    cyc("eret_fl",  7'b0100000, O_NORM, FLUSH, 1'b0);
    cyc("eret_hzd", 7'b0100000, O_STL,  RUN,   1'b1);
    cyc("eret_rel", 7'b0000000, O_NORM, STALL, 1'b0);
    cyc("eret_run", 7'b0000000, O_NORM, RUN,   1'b0);

    // Back-to-back exceptions hold FLUSH.
    cyc("bb_exc1",  7'b0000010, O_EXC,  RUN,   1'b0);
    cyc("bb_exc2",  7'b0000010, O_EXC,  FLUSH, 1'b0);
    cyc("bb_fl",    7'b0000000, O_NORM, FLUSH, 1'b0);
    cyc("bb_run",   7'b0000000, O_NORM, RUN,   1'b0);

    // Reset asserted while md_cnt = 7 and the FSM is in STALL.
    cyc("rdiv_iss", 7'b0001100, O_NORM,  RUN,   1'b0);
    cyc("rdiv_c10", 7'b0000000, O_NORMB, RUN,   1'b0);
    cyc("rdiv_c9",  7'b0000000, O_NORMB, RUN,   1'b0);
    cyc("rdiv_c8",  7'b0100000, O_STLB,  RUN,   1'b1);
    cyc("rdiv_rst", 7'b1110001, O_NORM,  STALL, 1'b0);
    cyc("rdiv_aft", 7'b0000000, O_NORM,  RUN,   1'b0);
    cyc("rdiv_idl", 7'b0000000, O_NORM,  RUN,   1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL expose: stall_hzd  in  1  D-stage operand hazard (source not yet forwardable).
REQ-004 SHALL expose: d_uses_md  in  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo.
REQ-005 SHALL expose: md_start  in  1  E-stage mult/div issuing this cycle.
REQ-006 SHALL expose: md_is_div  in  1  qualifies md_start: 1=div/divu, 0=mult/multu.
REQ-007 SHALL expose: exc_req  in  1  CP0 exception/interrupt request from M stage.
REQ-008 SHALL expose: eret_m  in  1  eret resident in M stage.
REQ-009 SHALL expose: f_en  out  1  PC register enable.
REQ-010 SHALL expose: d_en  out  1  F/D register enable.
REQ-011 SHALL expose: e_clr  out  1  D/E register bubble insert.
REQ-012 SHALL expose: req  out  1  flush to F/D, D/E, E/M, M/W registers (loads handler PC 0x0000_4180).
REQ-013 SHALL expose: pc_sel  out  2  next-PC source: 00 sequential/branch, 01 handler 0x0000_4180, 10 EPC.
REQ-014 SHALL expose: md_busy  out  1  multiply/divide unit occupied.
REQ-015 SHALL expose: stall_cnt  out  32  count of stalled cycles.

Function
REQ-016 SHALL hold a 4-bit md_cnt: md_start & ~exc_req loads 5 (mult) or 10 (div); otherwise decrements when nonzero; md_busy = (md_cnt != 0).
REQ-017 SHALL ignore md_start while exc_req=1 (issuing instr is flushed); an in-progress count SHALL continue through exceptions.
REQ-018 SHALL compute stall = stall_hzd | (d_uses_md & (md_busy | md_start)), masked to 0 in state FLUSH.
REQ-019 SHALL implement FSM states RUN, STALL, FLUSH.
REQ-020 SHALL transition: any state -> FLUSH on exc_req | eret_m; RUN -> STALL on stall; STALL -> RUN on ~stall; FLUSH -> RUN after exactly one cycle unless exc_req | eret_m again.
REQ-021 SHALL drive f_en = d_en = ~stall and e_clr = stall (combinational, same cycle).
REQ-022 SHALL drive req = exc_req combinationally; exc_req SHALL override stall (f_en=d_en=1, e_clr=0).
REQ-023 SHALL drive pc_sel = 01 when exc_req, else 10 when eret_m, else 00; exc_req wins if both asserted.
REQ-024 SHALL, on eret_m without exc_req, assert e_clr=1 and keep d_en=1 so the slot behind eret is squashed.

Reset
REQ-025 SHALL on reset force state=RUN, md_cnt=0, stall_cnt=0.
REQ-026 SHALL, while reset=1, drive f_en=1, d_en=1, e_clr=0, req=0, pc_sel=00, md_busy=0 regardless of other inputs.
REQ-027 SHALL abandon any in-progress md count or FLUSH cycle when reset asserts mid-operation.

Configuration
REQ-028 SHALL, with PIPE_PERF_CNT_EN defined, increment stall_cnt by 1 on every cycle with stall=1, wrapping 0xFFFF_FFFF -> 0.
REQ-029 SHALL, without PIPE_PERF_CNT_EN, tie stall_cnt to 0 with no counter flops; all other behaviour identical.

Verification
REQ-030 SHALL test: md_start=1, md_is_div=1, then d_uses_md=1 next cycle -> md_busy high 10 cycles, f_en=0 and e_clr=1 for 10 cycles, release on 11th.
REQ-031 SHALL test: stall_hzd=1 for 2 cycles -> state STALL, f_en=d_en=0, e_clr=1 both cycles, then RUN; stall_cnt=2 with macro, 0 without.
REQ-032 SHALL test: exc_req=1 during md-induced stall -> same cycle req=1, pc_sel=01, f_en=1; next cycle FLUSH with stall masked; md_cnt keeps decrementing.
REQ-033 SHALL test: exc_req=1 and eret_m=1 together -> pc_sel=01, req=1.
REQ-034 SHALL test: eret_m=1 alone -> pc_sel=10, e_clr=1, req=0, FSM enters FLUSH for 1 cycle.
REQ-035 SHALL test: reset asserted with md_cnt=7 -> next cycle md_busy=0, state RUN, stall_cnt=0.
